// File: rtl/jelly_rtos_pkg.sv
// Shared types for the RTOS scheduler: dispatch FSM states and default-width ID/priority types.
package jelly_rtos_pkg;

    localparam int unsigned DEF_TSKID_WIDTH  = 4;
    localparam int unsigned DEF_TSKPRI_WIDTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    typedef logic [DEF_TSKID_WIDTH-1:0]  tskid_t;
    typedef logic [DEF_TSKPRI_WIDTH-1:0] tskpri_t;

endpackage

// File: rtl/jelly_rtos_pri_select.sv
// Combinational search for the ready task with the lowest priority value; ties go to the lower ID.
module jelly_rtos_pri_select #(
    parameter int unsigned TSK_NUM      = 16,
    parameter int unsigned TSKID_WIDTH  = 4,
    parameter int unsigned TSKPRI_WIDTH = 4
) (
    input  logic [TSK_NUM-1:0]              rdq,
    input  logic [TSK_NUM*TSKPRI_WIDTH-1:0] tskpri,
    output logic                            valid_c,
    output logic [TSKID_WIDTH-1:0]          tskid_c
);

    logic                    best_valid;
    logic [TSKID_WIDTH-1:0]  best_id;
    logic [TSKPRI_WIDTH-1:0] best_pri;

    // Strict less-than while scanning upward keeps the lowest ID on equal priority.
    always_comb begin
        best_valid = 1'b0;
        best_id    = '0;
        best_pri   = '0;
        for (int i = 0; i < int'(TSK_NUM); i++) begin
            if (rdq[i] && (!best_valid || (tskpri[i*TSKPRI_WIDTH +: TSKPRI_WIDTH] < best_pri))) begin
                best_valid = 1'b1;
                best_id    = TSKID_WIDTH'(i);
                best_pri   = tskpri[i*TSKPRI_WIDTH +: TSKPRI_WIDTH];
            end
        end
        valid_c = best_valid;
        tskid_c = best_id;
    end

endmodule

// File: rtl/jelly_rtos_scheduler.sv
// Ready-queue bitmap, highest-priority selection and dispatch handshake toward the context-switch logic.
module jelly_rtos_scheduler
    import jelly_rtos_pkg::*;
#(
    parameter int unsigned TSK_NUM      = 16,
    parameter int unsigned TSKID_WIDTH  = 4,
    parameter int unsigned TSKPRI_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            cke,
    output logic                            busy,
    input  logic [TSK_NUM-1:0]              tsk_rdq_add,
    input  logic [TSK_NUM-1:0]              tsk_rdq_rmv,
    input  logic [TSK_NUM*TSKPRI_WIDTH-1:0] tsk_tskpri,
    output logic [TSK_NUM-1:0]              tsk_rdy_tsk,
    output logic [TSKID_WIDTH-1:0]          run_tskid,
    output logic                            run_valid,
    output logic                            dispatch_valid,
    output logic [TSKID_WIDTH-1:0]          dispatch_tskid,
    output logic                            dispatch_run,
    input  logic                            dispatch_ready
);

    state_t                 state;
    logic [TSK_NUM-1:0]     rdq_q;
    logic [TSK_NUM-1:0]     add_new_c;
    logic                   sel_valid_c;
    logic [TSKID_WIDTH-1:0] sel_tskid_c;
    logic                   sel_valid_q;
    logic [TSKID_WIDTH-1:0] sel_tskid_q;
    logic                   mismatch_c;

    // A held add request is acked on alternate cycles, so each request produces one ack.
    assign add_new_c = tsk_rdq_add & ~tsk_rdy_tsk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tsk_rdy_tsk <= '0;
            rdq_q       <= '0;
        end else if (cke) begin
            tsk_rdy_tsk <= add_new_c;
            rdq_q       <= (rdq_q | add_new_c) & ~tsk_rdq_rmv;
        end
    end

    jelly_rtos_pri_select #(
        .TSK_NUM      (TSK_NUM),
        .TSKID_WIDTH  (TSKID_WIDTH),
        .TSKPRI_WIDTH (TSKPRI_WIDTH)
    ) u_pri_select (
        .rdq     (rdq_q),
        .tskpri  (tsk_tskpri),
        .valid_c (sel_valid_c),
        .tskid_c (sel_tskid_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_valid_q <= 1'b0;
            sel_tskid_q <= '0;
        end else if (cke) begin
            sel_valid_q <= sel_valid_c;
            sel_tskid_q <= sel_tskid_c;
        end
    end

    assign mismatch_c = (sel_valid_q != run_valid) || (sel_valid_q && (sel_tskid_q != run_tskid));
    assign busy       = (|tsk_rdq_add) || (state == ST_REQ) || mismatch_c;

    // Dispatch FSM: request payload is frozen while waiting for the CPU to accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            run_tskid      <= '0;
            run_valid      <= 1'b0;
            dispatch_valid <= 1'b0;
            dispatch_tskid <= '0;
            dispatch_run   <= 1'b0;
        end else if (cke) begin
            case (state)
                ST_IDLE: begin
                    if (mismatch_c) begin
                        dispatch_tskid <= sel_valid_q ? sel_tskid_q : '0;
                        dispatch_run   <= sel_valid_q;
                        dispatch_valid <= 1'b1;
                        state          <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dispatch_ready) begin
                        run_tskid      <= dispatch_tskid;
                        run_valid      <= dispatch_run;
                        dispatch_valid <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
